// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA timing engine:
//   - default 640x480@60 timing-mode constants
//   - counter and character-cell field widths
//   - colour-field widths and the rgb888_t pixel type
//   - vga_ctl_t, the control word carried alongside the pixel-source latency
//   - sync_level(), which maps an internal "sync active" bit onto a wire level
// ---------------------------------------------------------------------------
package vga_pkg;

  // 640x480@60 timing mode (pixel clocks / lines)
  localparam int MODE_H_ACTIVE = 640;
  localparam int MODE_H_FP     = 16;
  localparam int MODE_H_SYNC   = 96;
  localparam int MODE_H_BP     = 48;
  localparam int MODE_V_ACTIVE = 480;
  localparam int MODE_V_FP     = 10;
  localparam int MODE_V_SYNC   = 2;
  localparam int MODE_V_BP     = 33;

  // Position and character-cell field widths
  localparam int CNT_W     = 10;
  localparam int CELL_XW   = 7;
  localparam int CELL_YW   = 7;
  localparam int CELL_PX_W = 4;
  localparam int CELL_PY_W = 5;

  // Colour fields
  localparam int COLOR_W = 8;
  localparam int RGB_W   = 3 * COLOR_W;

  typedef struct packed {
    logic [COLOR_W-1:0] r;
    logic [COLOR_W-1:0] g;
    logic [COLOR_W-1:0] b;
  } rgb888_t;

  // Control bits that must line up with the returned pixel data.
  // Sync bits are "active" flags; the wire polarity is applied at the output.
  typedef struct packed {
    logic frame_start;
    logic line_start;
    logic valid;
    logic vs_act;
    logic hs_act;
  } vga_ctl_t;

  function automatic logic sync_level(input logic active, input logic pol);
    return active ? pol : ~pol;
  endfunction

endpackage

// File: rtl/vga_timing_engine_if.sv
// ---------------------------------------------------------------------------
// vga_timing_engine_if
// Pixel-fetch bus between the timing engine and the pixel source.
//   req_valid/req_x/req_y : fetch request for one visible pixel
//   cell_x/cell_y         : character cell holding the requested pixel
//   cell_px/cell_py       : pixel/line offset inside that cell
//   vga_data/data_ok      : pixel returned DATA_LAT cycles after the request
// master = timing engine, slave = pixel source.
// ---------------------------------------------------------------------------
interface vga_timing_engine_if;
  import vga_pkg::*;

  logic                 req_valid;
  logic [CNT_W-1:0]     req_x;
  logic [CNT_W-1:0]     req_y;
  logic [CELL_XW-1:0]   cell_x;
  logic [CELL_YW-1:0]   cell_y;
  logic [CELL_PX_W-1:0] cell_px;
  logic [CELL_PY_W-1:0] cell_py;
  rgb888_t              vga_data;
  logic                 data_ok;

  modport master (
    output req_valid, req_x, req_y, cell_x, cell_y, cell_px, cell_py,
    input  vga_data, data_ok
  );

  modport slave (
    input  req_valid, req_x, req_y, cell_x, cell_y, cell_px, cell_py,
    output vga_data, data_ok
  );

endinterface

// File: rtl/vga_delay_line.sv
// ---------------------------------------------------------------------------
// vga_delay_line
// Fixed-depth shift register used to hold control bits back by the
// pixel-source read latency.
//   pclk, reset : clock, synchronous active-high reset (clears every stage)
//   d_i         : WIDTH-bit word entering the line
//   q_o         : the word presented DEPTH cycles earlier
// ---------------------------------------------------------------------------
module vga_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 2
) (
  input  logic             pclk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] stage_q [DEPTH];

  always_ff @(posedge pclk) begin
    // NOTE: every stage is reset, not just the first; a stale word left in a
    // later stage would emerge as a spurious sync or pulse after reset.
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_timing_engine.sv
// ---------------------------------------------------------------------------
// vga_timing_engine
// Generates VGA raster timing, issues per-pixel fetch requests (with
// character-cell coordinates) and merges the returned pixel data with
// latency-matched sync/valid/pulse signals. Missing data is replaced by
// UF_COLOR and latched in a sticky underflow flag.
//   pclk, reset       : pixel clock, synchronous active-high reset
//   en                : timing enable (0 parks the raster at (0,0))
//   clr_uf            : clears the underflow flag
//   fetch             : pixel-fetch bus (master side)
//   hsync, vsync      : syncs at HS_POL/VS_POL when active
//   valid, vga_r/g/b  : visible pixel and its colour
//   line_start        : pulse on the first active pixel of each line
//   frame_start       : pulse on pixel (0,0)
//   underflow         : sticky pixel-source underflow flag
// ---------------------------------------------------------------------------
module vga_timing_engine
  import vga_pkg::*;
#(
  parameter int                H_ACTIVE = MODE_H_ACTIVE,
  parameter int                H_FP     = MODE_H_FP,
  parameter int                H_SYNC   = MODE_H_SYNC,
  parameter int                H_BP     = MODE_H_BP,
  parameter int                V_ACTIVE = MODE_V_ACTIVE,
  parameter int                V_FP     = MODE_V_FP,
  parameter int                V_SYNC   = MODE_V_SYNC,
  parameter int                V_BP     = MODE_V_BP,
  parameter bit                HS_POL   = 1'b0,
  parameter bit                VS_POL   = 1'b0,
  parameter int                CELL_W   = 8,
  parameter int                CELL_H   = 16,
  parameter int                DATA_LAT = 2,
  parameter logic [RGB_W-1:0]  UF_COLOR = 24'h0000FF
) (
  input  logic                pclk,
  input  logic                reset,
  input  logic                en,
  input  logic                clr_uf,
  vga_timing_engine_if.master fetch,
  output logic                hsync,
  output logic                vsync,
  output logic                valid,
  output logic [COLOR_W-1:0]  vga_r,
  output logic [COLOR_W-1:0]  vga_g,
  output logic [COLOR_W-1:0]  vga_b,
  output logic                line_start,
  output logic                frame_start,
  output logic                underflow
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [CNT_W-1:0]     H_LAST   = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0]     V_LAST   = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0]     H_ACT    = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0]     V_ACT    = CNT_W'(V_ACTIVE);
  localparam logic [CNT_W-1:0]     HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
  localparam logic [CNT_W-1:0]     HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [CNT_W-1:0]     VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
  localparam logic [CNT_W-1:0]     VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [CELL_PX_W-1:0] CPX_LAST = CELL_PX_W'(CELL_W - 1);
  localparam logic [CELL_PY_W-1:0] CPY_LAST = CELL_PY_W'(CELL_H - 1);

  logic [CNT_W-1:0]     h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic [CELL_XW-1:0]   cell_x_q, cell_x_d;
  logic [CELL_YW-1:0]   cell_y_q, cell_y_d;
  logic [CELL_PX_W-1:0] cell_px_q, cell_px_d;
  logic [CELL_PY_W-1:0] cell_py_q, cell_py_d;
  logic                 underflow_q, underflow_d;
  logic                 h_wrap, v_wrap, req_valid, uf_set;
  vga_ctl_t             ctl_in, ctl_out;
  rgb888_t              pix;

  // Raster and character-cell counters. Cell coordinates are kept as
  // running counters that wrap at the cell size, avoiding any divider.
  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path
    // through this block leaves one unassigned and infers a latch.
    h_wrap    = (h_cnt_q == H_LAST);
    v_wrap    = (v_cnt_q == V_LAST);
    h_cnt_d   = h_cnt_q + 1'b1;
    v_cnt_d   = v_cnt_q;
    cell_px_d = cell_px_q + 1'b1;
    cell_x_d  = cell_x_q;
    cell_py_d = cell_py_q;
    cell_y_d  = cell_y_q;

    if (cell_px_q == CPX_LAST) begin
      cell_px_d = '0;
      cell_x_d  = cell_x_q + 1'b1;
    end

    if (h_wrap) begin
      h_cnt_d   = '0;
      cell_px_d = '0;
      cell_x_d  = '0;
      if (v_wrap) begin
        v_cnt_d   = '0;
        cell_py_d = '0;
        cell_y_d  = '0;
      end else begin
        v_cnt_d = v_cnt_q + 1'b1;
        if (cell_py_q == CPY_LAST) begin
          cell_py_d = '0;
          cell_y_d  = cell_y_q + 1'b1;
        end else begin
          cell_py_d = cell_py_q + 1'b1;
        end
      end
    end

    // Disabled: park at (0,0) so re-enabling starts a fresh frame.
    if (!en) begin
      h_cnt_d   = '0;
      v_cnt_d   = '0;
      cell_px_d = '0;
      cell_x_d  = '0;
      cell_py_d = '0;
      cell_y_d  = '0;
    end
  end

  // Request side. Reset gates the request combinationally so nothing is
  // fetched while reset is held, even before the first reset edge lands.
  assign req_valid = en & ~reset & (h_cnt_q < H_ACT) & (v_cnt_q < V_ACT);

  assign fetch.req_valid = req_valid;
  assign fetch.req_x     = req_valid ? h_cnt_q   : '0;
  assign fetch.req_y     = req_valid ? v_cnt_q   : '0;
  assign fetch.cell_x    = req_valid ? cell_x_q  : '0;
  assign fetch.cell_y    = req_valid ? cell_y_q  : '0;
  assign fetch.cell_px   = req_valid ? cell_px_q : '0;
  assign fetch.cell_py   = req_valid ? cell_py_q : '0;

  always_comb begin
    ctl_in             = '0;
    ctl_in.hs_act      = en & (h_cnt_q >= HS_BEG) & (h_cnt_q < HS_END);
    ctl_in.vs_act      = en & (v_cnt_q >= VS_BEG) & (v_cnt_q < VS_END);
    ctl_in.valid       = req_valid;
    ctl_in.line_start  = req_valid & (h_cnt_q == '0);
    ctl_in.frame_start = req_valid & (h_cnt_q == '0) & (v_cnt_q == '0);
  end

  // Hold control back by the source latency so it lines up with vga_data.
  vga_delay_line #(
    .WIDTH ($bits(vga_ctl_t)),
    .DEPTH (DATA_LAT)
  ) u_ctl_dly (
    .pclk  (pclk),
    .reset (reset),
    .d_i   (ctl_in),
    .q_o   (ctl_out)
  );

  // Output pixel: blank outside the visible area, substitute on underflow.
  always_comb begin
    pix = '0;
    if (ctl_out.valid) pix = fetch.data_ok ? fetch.vga_data : rgb888_t'(UF_COLOR);
  end

  // A new underflow wins over a simultaneous clear.
  assign uf_set      = ctl_out.valid & ~fetch.data_ok;
  assign underflow_d = uf_set | (underflow_q & ~clr_uf);

  always_ff @(posedge pclk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (reset) begin
      h_cnt_q     <= '0;
      v_cnt_q     <= '0;
      cell_x_q    <= '0;
      cell_y_q    <= '0;
      cell_px_q   <= '0;
      cell_py_q   <= '0;
      underflow_q <= 1'b0;
    end else begin
      h_cnt_q     <= h_cnt_d;
      v_cnt_q     <= v_cnt_d;
      cell_x_q    <= cell_x_d;
      cell_y_q    <= cell_y_d;
      cell_px_q   <= cell_px_d;
      cell_py_q   <= cell_py_d;
      underflow_q <= underflow_d;
    end
  end

  assign hsync       = sync_level(ctl_out.hs_act, HS_POL);
  assign vsync       = sync_level(ctl_out.vs_act, VS_POL);
  assign valid       = ctl_out.valid;
  assign line_start  = ctl_out.line_start;
  assign frame_start = ctl_out.frame_start;
  assign vga_r       = pix.r;
  assign vga_g       = pix.g;
  assign vga_b       = pix.b;
  assign underflow   = underflow_q;

endmodule

// File: doc/vga_timing_engine.md
VGA_TIMING_ENGINE -- requirements
Module: vga_timing_engine

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
  H_ACTIVE, 640, visible pixels per line
  H_FP, 16, horizontal front porch (pclk)
  H_SYNC, 96, hsync width
  H_BP, 48, horizontal back porch
  V_ACTIVE, 480, visible lines
  V_FP, 10, vertical front porch (lines)
  V_SYNC, 2, vsync width
  V_BP, 33, vertical back porch
  HS_POL, 0, hsync active level
  VS_POL, 0, vsync active level
  CELL_W, 8, character cell width (px)
  CELL_H, 16, character cell height (lines)
  DATA_LAT, 2, pixel-source read latency (cycles, 1..4)
  UF_COLOR, 24'h0000FF, pixel substituted on underflow
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
  pclk, in, 1, pixel clock
  reset, in, 1, reset (synchronous, active-high)
  en, in, 1, timing enable
  clr_uf, in, 1, clear underflow flag
  req_valid, out, 1, pixel fetch request (active region)
  req_x, out, 10, requested pixel column
  req_y, out, 10, requested pixel row
  cell_x, out, 7, character column of req_x
  cell_y, out, 7, character row of req_y
  cell_px, out, 4, pixel offset within cell
  cell_py, out, 5, line offset within cell
  vga_data, in, 24, {r,g,b}, returned DATA_LAT cycles after request
  data_ok, in, 1, vga_data valid alongside it
  hsync, out, 1, horizontal sync
  vsync, out, 1, vertical sync
  valid, out, 1, visible pixel on vga_r/g/b
  vga_r / vga_g / vga_b, out, 8 each, colour
  line_start, out, 1, one-cycle pulse at first active pixel of each line
  frame_start, out, 1, one-cycle pulse at pixel (0,0)
  underflow, out, 1, sticky pixel-source underflow flag

Function
REQ-003 SHALL count h_cnt 0..H_TOTAL-1 (H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP) and v_cnt 0..V_TOTAL-1; v_cnt SHALL advance only when h_cnt wraps, and SHALL wrap to 0 after V_TOTAL-1.
REQ-004 SHALL order each line/frame as active, front porch, sync, back porch; count 0 is the first active pixel.
REQ-005 SHALL assert req_valid when h_cnt<H_ACTIVE and v_cnt<V_ACTIVE and en=1; req_x=h_cnt, req_y=v_cnt when req_valid, else 0.
REQ-006 SHALL derive cell_x/cell_px/cell_y/cell_py from incrementing counters with wrap at CELL_W/CELL_H; no dividers; counters SHALL reset at h_cnt=0 (x) and v_cnt=0 (y).
REQ-007 SHALL delay hsync, vsync, valid, line_start and frame_start through a DATA_LAT-deep pipeline so that they align with vga_data.
REQ-008 Output colour: valid=0 gives rgb=0; valid=1 with data_ok=1 gives vga_data; valid=1 with data_ok=0 gives UF_COLOR and sets underflow.
REQ-009 underflow SHALL stay set until clr_uf or reset; a set event and clr_uf in the same cycle SHALL leave it set.
REQ-010 en=0 SHALL force h_cnt, v_cnt and cell counters to 0 and deassert req_valid; the pipeline SHALL keep draining, so outputs go blank/inactive-sync after DATA_LAT.
REQ-011 en 0->1 SHALL start at (0,0), giving frame_start DATA_LAT cycles later.
REQ-012 hsync SHALL be at HS_POL iff H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC; vsync SHALL follow the same rule on v_cnt with VS_POL.

Reset
REQ-013 Reset SHALL set counters and pipeline to 0, valid/req_valid/pulses/underflow=0, rgb=0, hsync=~HS_POL, vsync=~VS_POL.
REQ-014 Reset asserted mid-frame SHALL take effect the next edge; the first cycle after release SHALL be (0,0) if en=1.

Structure
REQ-015 The shared package vga_pkg SHALL hold the timing-mode constants (640x480@60 defaults), colour-field widths and an rgb888 typedef.
REQ-016 The {sync, valid, pulse} delay line SHALL be a sub-module vga_delay_line (parametrised width and depth).

Verification
REQ-017 Small params (H 8/2/2/2, V 4/1/1/1, DATA_LAT=2), en=1: hsync low at h_cnt 10..11; frame_start period is 14*7=98 cycles.
REQ-018 Source returns vga_data=h'ABCDEF, data_ok=1: rgb=AB/CD/EF exactly 2 cycles after the matching req_valid, and 0 in blanking.
REQ-019 data_ok=0 for one active pixel: that pixel shows UF_COLOR and underflow=1 persists; clr_uf clears it.
REQ-020 CELL_W=4: cell_x goes 0,0,0,0,1,1... and cell_px goes 0..3 repeatedly, both resetting at each line.
REQ-021 Reset at v_cnt=2: the next cycle has req_x=req_y=0, and all outputs match their reset values during reset.
REQ-022 en dropped mid-line: req_valid=0 immediately, valid=0 two cycles later, and en re-raised gives frame_start at +2.
